// File: rtl/vec_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vec_alu_sequencer
// Brief    : Steps one vector instruction across LANES lanes. Each lane gets
//            L ALU cycles (EXEC) followed by one writeback/flag cycle (WB).
//            A FIN cycle then pulses done. All outputs are registered.
// Options  : VSEQ_PERF_CNT_EN adds perf_busy_cycles. This is a saturating
//            16-bit count of busy cycles.
// Revision : 1.0 - initial release
// ============================================================================
module vec_alu_sequencer #(
  parameter int LANES   = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               opcode,
  output logic [2:0]               alu_op,
  output logic                     alu_en,
  output logic [$clog2(LANES)-1:0] lane_sel,
  output logic                     wb_en,
  output logic                     flag_en,
  output logic                     busy,
  output logic                     done
`ifdef VSEQ_PERF_CNT_EN
  ,
  output logic [15:0]              perf_busy_cycles
`endif
);

  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] C_LAST_LANE = LW'(LANES - 1);

  localparam logic [2:0] C_OP_NOP  = 3'b000;
  localparam logic [2:0] C_OP_PASS = 3'b001;
  localparam logic [2:0] C_OP_ADD  = 3'b010;
  localparam logic [2:0] C_OP_SUB  = 3'b011;
  localparam logic [2:0] C_OP_MUL  = 3'b100;
  localparam logic [2:0] C_OP_DIV  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t          r_state;
  logic [LW-1:0]   r_lane;
  logic [3:0]      r_cnt;
  logic [3:0]      r_opcode;

  // Opcode to ALU operation map.
  function automatic logic [2:0] decode(input logic [3:0] op);
    logic [2:0] d;
    d = C_OP_NOP;
    case (op)
      4'b0100, 4'b1101, 4'b1110, 4'b1111: d = C_OP_PASS;
      4'b1000, 4'b0000, 4'b0001:          d = C_OP_ADD;
      4'b1001, 4'b0101, 4'b0110:          d = C_OP_SUB;
      4'b1010:                            d = C_OP_MUL;
      4'b1011:                            d = C_OP_DIV;
      default:                            d = C_OP_NOP;
    endcase
    return d;
  endfunction

  // Per-lane ALU cycles minus one, which is the EXEC countdown start value.
  function automatic logic [3:0] lat_m1(input logic [2:0] d);
    logic [3:0] l;
    l = 4'd0;
    if (d == C_OP_MUL) l = 4'(MUL_LAT - 1);
    if (d == C_OP_DIV) l = 4'(DIV_LAT - 1);
    return l;
  endfunction

  // Compares (0101, 0110) and the bare PASS (0100) update no register.
  function automatic logic wants_wb(input logic [3:0] op);
    return !(op == 4'b0100 || op == 4'b0101 || op == 4'b0110);
  endfunction

  // Only compares update flags.
  function automatic logic wants_flag(input logic [3:0] op);
    return (op == 4'b0101 || op == 4'b0110);
  endfunction

  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);

  // Sequencer FSM. Each output is loaded with the value it must hold in the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lane   <= '0;
      r_cnt    <= 4'd0;
      r_opcode <= 4'd0;
      alu_op   <= C_OP_NOP;
      alu_en   <= 1'b0;
      lane_sel <= '0;
      wb_en    <= 1'b0;
      flag_en  <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opcode <= opcode;
            r_lane   <= '0;
            lane_sel <= '0;
            if (decode(opcode) == C_OP_NOP) begin
              r_state <= FIN;
              done    <= 1'b1;
            end else begin
              r_state <= EXEC;
              r_cnt   <= lat_m1(decode(opcode));
              alu_op  <= decode(opcode);
              alu_en  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (r_cnt == 4'd0) begin
            r_state <= WB;
            alu_en  <= 1'b0;
            wb_en   <= wants_wb(r_opcode);
            flag_en <= wants_flag(r_opcode);
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WB: begin
          wb_en   <= 1'b0;
          flag_en <= 1'b0;
          if (r_lane == C_LAST_LANE) begin
            r_state  <= FIN;
            alu_op   <= C_OP_NOP;
            lane_sel <= '0;
            done     <= 1'b1;
          end else begin
            r_state  <= EXEC;
            r_lane   <= r_lane + 1'b1;
            lane_sel <= r_lane + 1'b1;
            r_cnt    <= lat_m1(alu_op);
            alu_en   <= 1'b1;
          end
        end
        FIN: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef VSEQ_PERF_CNT_EN
  // Saturating count of cycles spent busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cycles <= 16'd0;
    end else if (busy && perf_busy_cycles != 16'hFFFF) begin
      perf_busy_cycles <= perf_busy_cycles + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_alu_sequencer
// Brief    : Table-driven directed bench for vec_alu_sequencer at default
//            parameters. It also runs hand sequences for NOP back-to-back
//            issue and for reset taken in the middle of an instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_alu_sequencer;

  localparam int LANES   = 4;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;
  localparam int LW      = $clog2(LANES);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    opcode = 4'd0;
  logic [2:0]    alu_op;
  logic          alu_en;
  logic [LW-1:0] lane_sel;
  logic          wb_en;
  logic          flag_en;
  logic          busy;
  logic          done;
`ifdef VSEQ_PERF_CNT_EN
  logic [15:0]   perf_busy_cycles;
`endif

  vec_alu_sequencer #(
    .LANES  (LANES),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .opcode  (opcode),
    .alu_op  (alu_op),
    .alu_en  (alu_en),
    .lane_sel(lane_sel),
    .wb_en   (wb_en),
    .flag_en (flag_en),
    .busy    (busy),
    .done    (done)
`ifdef VSEQ_PERF_CNT_EN
    ,
    .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] opc;
    logic [2:0] aop;
    int         n_wb;
    int         n_flag;
    int         n_en;
    int         lat;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one opcode with in_valid held high throughout, then check every
  // cycle up to done against the record.
  task automatic run_vec(input vec_t v);
    int   k, nwb, nfl, nen, lanes, bad, lat;
    logic seen, prev_en;
`ifdef VSEQ_PERF_CNT_EN
    int   p0;
`endif
    @(negedge clk);
    chk($sformatf("ready_idle op%b", v.opc), int'(in_ready), 1);
`ifdef VSEQ_PERF_CNT_EN
    p0 = int'(perf_busy_cycles);
`endif
    in_valid = 1'b1;
    opcode   = v.opc;
    @(posedge clk);
    k = 0; nwb = 0; nfl = 0; nen = 0; lanes = 0; bad = 0; lat = -1;
    seen = 1'b0; prev_en = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (alu_en) begin
        nen++;
        if (int'(lane_sel) != lanes) bad++;
      end
      if (busy && !done && !alu_en && prev_en) begin
        if (int'(lane_sel) != lanes) bad++;
        lanes++;
      end
      if (wb_en) nwb++;
      if (flag_en) nfl++;
      if (alu_en && (wb_en || flag_en)) bad++;
      if (busy && !done && alu_op != v.aop) bad++;
      if (done && (alu_op != 3'd0 || lane_sel != '0 || alu_en)) bad++;
      if (busy == in_ready) bad++;
      prev_en = alu_en;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    in_valid = 1'b0;
    chk($sformatf("done_lat op%b", v.opc), lat, v.lat);
    chk($sformatf("wb_cnt op%b", v.opc), nwb, v.n_wb);
    chk($sformatf("flag_cnt op%b", v.opc), nfl, v.n_flag);
    chk($sformatf("alu_en_cnt op%b", v.opc), nen, v.n_en);
    chk($sformatf("cycle_errs op%b", v.opc), bad, 0);
    @(negedge clk);
    chk($sformatf("idle_after op%b", v.opc), int'(busy), 0);
`ifdef VSEQ_PERF_CNT_EN
    chk($sformatf("perf_delta op%b", v.opc), int'(perf_busy_cycles) - p0, v.lat);
`endif
  endtask

  initial begin
    int   k, nen, lat, nbad;
    logic found;

    //            opc      aop   wb fl en  lat
    tbl[0]  = '{4'b1000, 3'd2, 4, 0, 4,  9};
    tbl[1]  = '{4'b0000, 3'd2, 4, 0, 4,  9};
    tbl[2]  = '{4'b0001, 3'd2, 4, 0, 4,  9};
    tbl[3]  = '{4'b1001, 3'd3, 4, 0, 4,  9};
    tbl[4]  = '{4'b0101, 3'd3, 0, 4, 4,  9};
    tbl[5]  = '{4'b0110, 3'd3, 0, 4, 4,  9};
    tbl[6]  = '{4'b0100, 3'd1, 0, 0, 4,  9};
    tbl[7]  = '{4'b1101, 3'd1, 4, 0, 4,  9};
    tbl[8]  = '{4'b1110, 3'd1, 4, 0, 4,  9};
    tbl[9]  = '{4'b1111, 3'd1, 4, 0, 4,  9};
    tbl[10] = '{4'b1010, 3'd4, 4, 0, 8,  13};
    tbl[11] = '{4'b1011, 3'd5, 4, 0, 32, 37};
    tbl[12] = '{4'b0011, 3'd0, 0, 0, 0,  1};
    tbl[13] = '{4'b0010, 3'd0, 0, 0, 0,  1};
    tbl[14] = '{4'b0111, 3'd0, 0, 0, 0,  1};
    tbl[15] = '{4'b1100, 3'd0, 0, 0, 0,  1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({alu_op, alu_en, lane_sel, wb_en, flag_en, busy, done}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(in_ready), 1);

    for (int i = 0; i < NV; i++) run_vec(tbl[i]);

    // NOP with in_valid held, then ADD accepted the cycle after done
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    chk("nop_done_next", int'(done), 1);
    chk("nop_no_alu_en", int'(alu_en), 0);
    opcode = 4'b0000;
    @(negedge clk);
    chk("nop_then_idle_ready", int'(in_ready), 1);
    @(posedge clk);
    k = 0; nen = 0; lat = -1; found = 1'b0;
    while (!found && k < 100) begin
      @(negedge clk);
      k++;
      if (alu_en) nen++;
      if (done) begin
        found = 1'b1;
        lat   = k;
      end
    end
    in_valid = 1'b0;
    chk("add_after_nop_lat", lat, 9);
    chk("add_after_nop_en", nen, 4);
    @(negedge clk);

    // MUL interrupted by reset while working on lane 2
    in_valid = 1'b1;
    opcode   = 4'b1010;
    @(posedge clk);
    found = 1'b0;
    k = 0;
    while (!found && k < 50) begin
      @(negedge clk);
      k++;
      if (alu_en && lane_sel == LW'(2)) found = 1'b1;
    end
    chk("mul_reached_lane2", int'(found), 1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({alu_op, alu_en, lane_sel, wb_en, flag_en, busy, done}), 0);
    @(negedge clk);
    rst = 1'b0;
    nbad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || wb_en || flag_en || busy || alu_en) nbad++;
    end
    chk("no_activity_after_reset", nbad, 0);
    chk("ready_after_midreset", int'(in_ready), 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
